// File: rtl/p405s_srm_pkg.sv
// Shared definitions for the SRM issue/writeback stage: op encodings, srmL2 layout,
// control-bus bit positions, CR0 bit positions and the per-stage occupancy state.
package p405s_srm_pkg;

  typedef enum logic [2:0] {
    SRM_OP_RLWINM = 3'd0,
    SRM_OP_RLWNM  = 3'd1,
    SRM_OP_RLWIMI = 3'd2,
    SRM_OP_SLW    = 3'd3,
    SRM_OP_SRW    = 3'd4,
    SRM_OP_SRAW   = 3'd5,
    SRM_OP_SRAWI  = 3'd6,
    SRM_OP_RSVD   = 3'd7
  } srmOp_e;

  // srmL2 = {shiftAmtMsb, shiftAmt[0:4], mb[0:4], me[0:4]}
  localparam int SRM_L2_MSB_BIT = 15;
  localparam int SRM_L2_AMT_LSB = 10;
  localparam int SRM_L2_MB_LSB  = 5;
  localparam int SRM_L2_ME_LSB  = 0;

  localparam int SRM_CNTL_RLWIMI  = 3;
  localparam int SRM_CNTL_SHIFTLT = 2;
  localparam int SRM_CNTL_SHIFTRT = 1;
  localparam int SRM_CNTL_SHRTALG = 0;

  localparam int SRM_CR0_LT = 3;
  localparam int SRM_CR0_GT = 2;
  localparam int SRM_CR0_EQ = 1;
  localparam int SRM_CR0_SO = 0;

  typedef enum logic {
    STAGE_EMPTY = 1'b0,
    STAGE_FULL  = 1'b1
  } stage_e;

  function automatic logic srmWritesCa(input srmOp_e op);
    return (op == SRM_OP_SRAW) || (op == SRM_OP_SRAWI);
  endfunction

endpackage

// File: rtl/p405s_srm_issue_if.sv
// DCD / EXE-SRM / writeback signal bundle of the SRM issue stage.
// The slave modport is the issue stage; the master modport is its surroundings.
interface p405s_srm_issue_if #(
  parameter int RES_W = 32,
  parameter int TAG_W = 5
);
  logic             dcdValid;
  logic             dcdReady;
  logic [2:0]       dcdOp;
  logic [4:0]       dcdSh;
  logic [4:0]       dcdMb;
  logic [4:0]       dcdMe;
  logic [5:0]       dcdRb;
  logic             dcdRc;
  logic [TAG_W-1:0] dcdTag;
  logic [15:0]      srmL2;
  logic [3:0]       srmCntlBus;
  logic             exeSrmUnitEn_NEG;
  logic [RES_W-1:0] srmOut;
  logic             srmCA;
  logic [2:0]       srmCcBits;
  logic             xerSo;
  logic             wbValid;
  logic             wbAccept;
  logic [RES_W-1:0] wbData;
  logic             wbCa;
  logic [TAG_W-1:0] wbTag;
  logic             wbCaWe;
  logic [3:0]       wbCr0;
  logic             wbCr0We;

  modport slave (
    input  dcdValid, dcdOp, dcdSh, dcdMb, dcdMe, dcdRb, dcdRc, dcdTag,
    input  srmOut, srmCA, srmCcBits, xerSo, wbAccept,
    output dcdReady, srmL2, srmCntlBus, exeSrmUnitEn_NEG,
    output wbValid, wbData, wbCa, wbTag, wbCaWe, wbCr0, wbCr0We
  );

  modport master (
    output dcdValid, dcdOp, dcdSh, dcdMb, dcdMe, dcdRb, dcdRc, dcdTag,
    output srmOut, srmCA, srmCcBits, xerSo, wbAccept,
    input  dcdReady, srmL2, srmCntlBus, exeSrmUnitEn_NEG,
    input  wbValid, wbData, wbCa, wbTag, wbCaWe, wbCr0, wbCr0We
  );
endinterface

// File: rtl/p405s_srmFieldPack.sv
// Combinational translation of a decoded SRM op into the srmL2 field word and
// the SRM control bus; the reserved op degrades to an all-zero rlwinm.
module p405s_srmFieldPack
  import p405s_srm_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [4:0]  i_sh,
  input  logic [4:0]  i_mb,
  input  logic [4:0]  i_me,
  input  logic [5:0]  i_rb,
  output logic [15:0] o_l2,
  output logic [3:0]  o_cntl
);
  srmOp_e     w_op;
  logic       w_msb;
  logic [4:0] w_amt;
  logic [4:0] w_mb;
  logic [4:0] w_me;

  assign w_op = srmOp_e'(i_op);

  always_comb begin
    w_msb = 1'b0;
    w_amt = i_sh;
    w_mb  = i_mb;
    w_me  = i_me;
    case (w_op)
      SRM_OP_RLWINM, SRM_OP_RLWIMI: ;
      SRM_OP_RLWNM: w_amt = i_rb[4:0];
      // slw masks off the bits rotated in from the bottom
      SRM_OP_SLW: begin
        w_msb = i_rb[5];
        w_amt = i_rb[4:0];
        w_mb  = 5'd0;
        w_me  = ~i_rb[4:0];
      end
      SRM_OP_SRW, SRM_OP_SRAW: begin
        w_msb = i_rb[5];
        w_amt = i_rb[4:0];
        w_mb  = i_rb[4:0];
        w_me  = 5'd31;
      end
      SRM_OP_SRAWI: begin
        w_mb = i_sh;
        w_me = 5'd31;
      end
      default: begin
        w_amt = 5'd0;
        w_mb  = 5'd0;
        w_me  = 5'd0;
      end
    endcase
  end

  assign o_l2 = {w_msb, w_amt, w_mb, w_me};

  assign o_cntl[SRM_CNTL_RLWIMI]  = (w_op == SRM_OP_RLWIMI);
  assign o_cntl[SRM_CNTL_SHIFTLT] = (w_op == SRM_OP_SLW);
  assign o_cntl[SRM_CNTL_SHIFTRT] = (w_op == SRM_OP_SRW) || (w_op == SRM_OP_SRAW) ||
                                    (w_op == SRM_OP_SRAWI);
  assign o_cntl[SRM_CNTL_SHRTALG] = (w_op == SRM_OP_SRAW) || (w_op == SRM_OP_SRAWI);

endmodule

// File: rtl/p405s_srm_issue.sv
// SRM issue/writeback stage: L2 field latch followed by a result register, valid/ready flow.
// Optional macro SRM_CR0_UPDATE_EN enables CR0 capture and its write enable from the Rc bit.
module p405s_srm_issue
  import p405s_srm_pkg::*;
#(
  parameter int RES_W = 32,
  parameter int TAG_W = 5
) (
  input logic                CB,
  input logic                resetCore,
  p405s_srm_issue_if.slave   bus
);
  logic [15:0]      w_l2Pack;
  logic [3:0]       w_cntlPack;
  logic             w_resFree;
  logic             w_l2Adv;
  logic             w_dcdReady;
  logic             w_accept;
  logic [3:0]       w_cr0Next;
  logic             w_cr0WeNext;

  stage_e           r_l2State;
  logic [15:0]      r_srmL2;
  logic [3:0]       r_srmCntl;
  logic [TAG_W-1:0] r_l2Tag;
  logic             r_l2CaWe;
  stage_e           r_resState;
  logic [RES_W-1:0] r_wbData;
  logic             r_wbCa;
  logic [TAG_W-1:0] r_wbTag;
  logic             r_wbCaWe;
  logic [3:0]       r_wbCr0;
  logic             r_wbCr0We;

  p405s_srmFieldPack u_fieldPack (
    .i_op   (bus.dcdOp),
    .i_sh   (bus.dcdSh),
    .i_mb   (bus.dcdMb),
    .i_me   (bus.dcdMe),
    .i_rb   (bus.dcdRb),
    .o_l2   (w_l2Pack),
    .o_cntl (w_cntlPack)
  );

  assign w_resFree  = (r_resState == STAGE_EMPTY) || bus.wbAccept;
  assign w_l2Adv    = (r_l2State == STAGE_FULL) && w_resFree;
  assign w_dcdReady = (r_l2State == STAGE_EMPTY) || w_l2Adv;
  assign w_accept   = bus.dcdValid && w_dcdReady;

`ifdef SRM_CR0_UPDATE_EN
  logic r_l2Rc;

  always_ff @(posedge CB) begin
    if (resetCore) r_l2Rc <= 1'b0;
    else if (w_accept) r_l2Rc <= bus.dcdRc;
  end

  assign w_cr0Next   = {bus.srmCcBits, bus.xerSo};
  assign w_cr0WeNext = r_l2Rc;
`else
  logic w_unusedCr0Inputs;

  assign w_unusedCr0Inputs = bus.dcdRc ^ bus.xerSo ^ (^bus.srmCcBits);
  assign w_cr0Next         = 4'd0;
  assign w_cr0WeNext       = 1'b0;
`endif

  // L2 field latch; fields keep their last value once the op moves on
  always_ff @(posedge CB) begin
    if (resetCore) begin
      r_l2State <= STAGE_EMPTY;
      r_srmL2   <= 16'd0;
      r_srmCntl <= 4'd0;
      r_l2Tag   <= '0;
      r_l2CaWe  <= 1'b0;
    end else if (w_accept) begin
      r_l2State <= STAGE_FULL;
      r_srmL2   <= w_l2Pack;
      r_srmCntl <= w_cntlPack;
      r_l2Tag   <= bus.dcdTag;
      r_l2CaWe  <= srmWritesCa(srmOp_e'(bus.dcdOp));
    end else if (w_l2Adv) begin
      r_l2State <= STAGE_EMPTY;
    end
  end

  always_ff @(posedge CB) begin
    if (resetCore) begin
      r_resState <= STAGE_EMPTY;
      r_wbData   <= '0;
      r_wbCa     <= 1'b0;
      r_wbTag    <= '0;
      r_wbCaWe   <= 1'b0;
      r_wbCr0    <= 4'd0;
      r_wbCr0We  <= 1'b0;
    end else if (w_resFree) begin
      r_resState <= r_l2State;
      if (w_l2Adv) begin
        r_wbData  <= bus.srmOut;
        r_wbCa    <= r_l2CaWe && bus.srmCA;
        r_wbTag   <= r_l2Tag;
        r_wbCaWe  <= r_l2CaWe;
        r_wbCr0   <= w_cr0Next;
        r_wbCr0We <= w_cr0WeNext;
      end
    end
  end

  assign bus.dcdReady         = w_dcdReady;
  assign bus.srmL2            = r_srmL2;
  assign bus.srmCntlBus       = r_srmCntl;
  assign bus.exeSrmUnitEn_NEG = (r_l2State == STAGE_EMPTY);
  assign bus.wbValid          = (r_resState == STAGE_FULL);
  assign bus.wbData           = r_wbData;
  assign bus.wbCa             = r_wbCa;
  assign bus.wbTag            = r_wbTag;
  assign bus.wbCaWe           = r_wbCaWe;
  assign bus.wbCr0            = r_wbCr0;
  assign bus.wbCr0We          = r_wbCr0We;

endmodule

// File: tb/tb_p405s_srm_issue.sv
// Directed bench for p405s_srm_issue with a behavioural SRM unit model driving srmOut/srmCA/srmCcBits.
// Honours SRM_CR0_UPDATE_EN for the expected CR0 values.
module tb_p405s_srm_issue;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  sh;
    logic [4:0]  mb;
    logic [4:0]  me;
    logic [5:0]  rb;
    logic        rc;
    logic [4:0]  tag;
    logic [31:0] rs;
    logic        so;
    logic [15:0] expL2;
    logic [3:0]  expCntl;
    logic [31:0] expData;
    logic        expCa;
    logic        expCaWe;
    logic [3:0]  expCr0;
  } vec_t;

  logic CB;
  logic resetCore;
  int   checks;
  int   errors;

  logic [31:0] curRs;
  logic [31:0] l2Rs;
  logic        mMsb;
  logic [4:0]  mAmt;
  logic [4:0]  mMb;
  logic [4:0]  mMe;
  logic [31:0] mMask;
  logic [31:0] mRot;
  logic [31:0] mRes;
  logic        mCa;
  logic [2:0]  mCc;

  vec_t vecs[10];
  vec_t stallOps[3];

  p405s_srm_issue_if #(.RES_W(32), .TAG_W(5)) bus ();

  p405s_srm_issue #(.RES_W(32), .TAG_W(5)) dut (
    .CB        (CB),
    .resetCore (resetCore),
    .bus       (bus)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  // Operand rS follows the op into L2, as the EXE operand buses would
  always @(posedge CB) begin
    if (resetCore) l2Rs <= 32'd0;
    else if (bus.dcdValid && bus.dcdReady) l2Rs <= curRs;
  end

  // Reference SRM unit: rotate-and-mask for rotates, plain shifts for the shift forms
  always_comb begin
    mMsb  = bus.srmL2[15];
    mAmt  = bus.srmL2[14:10];
    mMb   = bus.srmL2[9:5];
    mMe   = bus.srmL2[4:0];
    mMask = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((int'(mMb) <= int'(mMe)) ? (i >= int'(mMb) && i <= int'(mMe))
                                   : (i >= int'(mMb) || i <= int'(mMe)))
        mMask[31-i] = 1'b1;
    end
    mRot = (l2Rs << mAmt) | (l2Rs >> (6'd32 - {1'b0, mAmt}));
    mRes = mRot & mMask;
    mCa  = 1'b0;
    if (bus.srmCntlBus[2]) begin
      mRes = mMsb ? 32'd0 : (l2Rs << mAmt);
    end else if (bus.srmCntlBus[1]) begin
      if (bus.srmCntlBus[0]) begin
        if (mMsb) begin
          mRes = {32{l2Rs[31]}};
          mCa  = l2Rs[31] && (l2Rs != 32'd0);
        end else begin
          mRes = $unsigned($signed(l2Rs) >>> mAmt);
          mCa  = l2Rs[31] && ((l2Rs & ((32'h1 << mAmt) - 32'h1)) != 32'd0);
        end
      end else begin
        mRes = mMsb ? 32'd0 : (l2Rs >> mAmt);
      end
    end
    mCc = {mRes[31], !mRes[31] && (mRes != 32'd0), mRes == 32'd0};
  end

  assign bus.srmOut    = mRes;
  assign bus.srmCA     = mCa;
  assign bus.srmCcBits = mCc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.dcdValid = 1'b1;
    bus.dcdOp    = v.op;
    bus.dcdSh    = v.sh;
    bus.dcdMb    = v.mb;
    bus.dcdMe    = v.me;
    bus.dcdRb    = v.rb;
    bus.dcdRc    = v.rc;
    bus.dcdTag   = v.tag;
    bus.xerSo    = v.so;
    curRs        = v.rs;
  endtask

  // Starts and ends #1 after a rising edge; one op through both stages with writeback ready
  task automatic runVector(input vec_t v, input int idx);
    logic [3:0] expCr0;
    logic       expCr0We;
`ifdef SRM_CR0_UPDATE_EN
    expCr0   = v.expCr0;
    expCr0We = v.rc;
`else
    expCr0   = 4'd0;
    expCr0We = 1'b0;
`endif
    applyStimulus(v);
    @(negedge CB);
    checkOutput($sformatf("v%0d dcdReady", idx), {31'd0, bus.dcdReady}, 32'd1);
    @(posedge CB); #1;
    bus.dcdValid = 1'b0;
    @(negedge CB);
    checkOutput($sformatf("v%0d srmL2", idx), {16'd0, bus.srmL2}, {16'd0, v.expL2});
    checkOutput($sformatf("v%0d srmCntlBus", idx), {28'd0, bus.srmCntlBus}, {28'd0, v.expCntl});
    checkOutput($sformatf("v%0d enNeg full", idx), {31'd0, bus.exeSrmUnitEn_NEG}, 32'd0);
    checkOutput($sformatf("v%0d wbValid early", idx), {31'd0, bus.wbValid}, 32'd0);
    @(posedge CB); #1;
    @(negedge CB);
    checkOutput($sformatf("v%0d wbValid", idx), {31'd0, bus.wbValid}, 32'd1);
    checkOutput($sformatf("v%0d wbData", idx), bus.wbData, v.expData);
    checkOutput($sformatf("v%0d wbCa", idx), {31'd0, bus.wbCa}, {31'd0, v.expCa});
    checkOutput($sformatf("v%0d wbCaWe", idx), {31'd0, bus.wbCaWe}, {31'd0, v.expCaWe});
    checkOutput($sformatf("v%0d wbTag", idx), {27'd0, bus.wbTag}, {27'd0, v.tag});
    checkOutput($sformatf("v%0d wbCr0", idx), {28'd0, bus.wbCr0}, {28'd0, expCr0});
    checkOutput($sformatf("v%0d wbCr0We", idx), {31'd0, bus.wbCr0We}, {31'd0, expCr0We});
    checkOutput($sformatf("v%0d enNeg empty", idx), {31'd0, bus.exeSrmUnitEn_NEG}, 32'd1);
    checkOutput($sformatf("v%0d srmL2 retained", idx), {16'd0, bus.srmL2}, {16'd0, v.expL2});
    @(posedge CB); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    //            op    sh     mb     me     rb      rc    tag    rs            so    l2        cntl   data          ca    caWe  cr0
    vecs[0] = '{3'd0, 5'd8,  5'd24, 5'd31, 6'h00, 1'b1, 5'd3,  32'h12345678, 1'b0, 16'h231F, 4'h0, 32'h00000012, 1'b0, 1'b0, 4'b0100};
    vecs[1] = '{3'd3, 5'd0,  5'd0,  5'd0,  6'h20, 1'b0, 5'd4,  32'hFFFFFFFF, 1'b0, 16'h801F, 4'h4, 32'h00000000, 1'b0, 1'b0, 4'b0010};
    vecs[2] = '{3'd4, 5'd0,  5'd0,  5'd0,  6'h04, 1'b1, 5'd5,  32'hFFFFFFFF, 1'b0, 16'h109F, 4'h2, 32'h0FFFFFFF, 1'b0, 1'b0, 4'b0100};
    vecs[3] = '{3'd5, 5'd0,  5'd0,  5'd0,  6'h01, 1'b1, 5'd6,  32'h80000001, 1'b0, 16'h043F, 4'h3, 32'hC0000000, 1'b1, 1'b1, 4'b1000};
    vecs[4] = '{3'd6, 5'd0,  5'd0,  5'd0,  6'h00, 1'b0, 5'd7,  32'h80000001, 1'b0, 16'h001F, 4'h3, 32'h80000001, 1'b0, 1'b1, 4'b1000};
    vecs[5] = '{3'd0, 5'd0,  5'd0,  5'd15, 6'h00, 1'b1, 5'd8,  32'h000000FF, 1'b1, 16'h000F, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'b0011};
    vecs[6] = '{3'd1, 5'd9,  5'd0,  5'd31, 6'h24, 1'b0, 5'd9,  32'h12345678, 1'b0, 16'h101F, 4'h0, 32'h23456781, 1'b0, 1'b0, 4'b0100};
    vecs[7] = '{3'd7, 5'd5,  5'd3,  5'd9,  6'h3F, 1'b1, 5'd17, 32'h12345678, 1'b0, 16'h0000, 4'h0, 32'h00000000, 1'b0, 1'b0, 4'b0010};
    vecs[8] = '{3'd4, 5'd0,  5'd0,  5'd0,  6'h3F, 1'b0, 5'd18, 32'hFFFFFFFF, 1'b0, 16'hFFFF, 4'h2, 32'h00000000, 1'b0, 1'b0, 4'b0010};
    vecs[9] = '{3'd2, 5'd16, 5'd0,  5'd15, 6'h00, 1'b1, 5'd31, 32'h0000ABCD, 1'b1, 16'h400F, 4'h8, 32'hABCD0000, 1'b0, 1'b0, 4'b1001};

    stallOps[0] = '{3'd0, 5'd1, 5'd0, 5'd31, 6'h00, 1'b0, 5'd10, 32'h1, 1'b0, 16'h041F, 4'h0, 32'h2, 1'b0, 1'b0, 4'b0100};
    stallOps[1] = '{3'd0, 5'd2, 5'd0, 5'd31, 6'h00, 1'b0, 5'd11, 32'h1, 1'b0, 16'h081F, 4'h0, 32'h4, 1'b0, 1'b0, 4'b0100};
    stallOps[2] = '{3'd0, 5'd3, 5'd0, 5'd31, 6'h00, 1'b0, 5'd12, 32'h1, 1'b0, 16'h0C1F, 4'h0, 32'h8, 1'b0, 1'b0, 4'b0100};

    resetCore    = 1'b1;
    bus.dcdValid = 1'b0;
    bus.dcdOp    = 3'd0;
    bus.dcdSh    = 5'd0;
    bus.dcdMb    = 5'd0;
    bus.dcdMe    = 5'd0;
    bus.dcdRb    = 6'd0;
    bus.dcdRc    = 1'b0;
    bus.dcdTag   = 5'd0;
    bus.xerSo    = 1'b0;
    bus.wbAccept = 1'b1;
    curRs        = 32'd0;

    repeat (2) @(posedge CB);
    @(negedge CB);
    checkOutput("reset wbValid", {31'd0, bus.wbValid}, 32'd0);
    checkOutput("reset enNeg", {31'd0, bus.exeSrmUnitEn_NEG}, 32'd1);
    checkOutput("reset srmL2", {16'd0, bus.srmL2}, 32'd0);
    checkOutput("reset dcdReady", {31'd0, bus.dcdReady}, 32'd1);
    @(posedge CB); #1;
    resetCore = 1'b0;

    for (int i = 0; i < 10; i++) runVector(vecs[i], i);

    // Reset with RES and L2 both occupied discards everything
    bus.wbAccept = 1'b0;
    applyStimulus(vecs[0]);
    @(posedge CB); #1;
    applyStimulus(vecs[3]);
    @(posedge CB); #1;
    bus.dcdValid = 1'b0;
    @(negedge CB);
    checkOutput("pre-reset wbValid", {31'd0, bus.wbValid}, 32'd1);
    checkOutput("pre-reset enNeg", {31'd0, bus.exeSrmUnitEn_NEG}, 32'd0);
    checkOutput("pre-reset dcdReady", {31'd0, bus.dcdReady}, 32'd0);
    @(posedge CB); #1;
    resetCore = 1'b1;
    @(posedge CB); #1;
    resetCore = 1'b0;
    @(negedge CB);
    checkOutput("midreset wbValid", {31'd0, bus.wbValid}, 32'd0);
    checkOutput("midreset enNeg", {31'd0, bus.exeSrmUnitEn_NEG}, 32'd1);
    checkOutput("midreset srmL2", {16'd0, bus.srmL2}, 32'd0);
    checkOutput("midreset srmCntlBus", {28'd0, bus.srmCntlBus}, 32'd0);
    checkOutput("midreset wbData", bus.wbData, 32'd0);
    checkOutput("midreset wbCa", {31'd0, bus.wbCa}, 32'd0);
    checkOutput("midreset wbCaWe", {31'd0, bus.wbCaWe}, 32'd0);
    checkOutput("midreset wbTag", {27'd0, bus.wbTag}, 32'd0);
    checkOutput("midreset wbCr0", {28'd0, bus.wbCr0}, 32'd0);
    checkOutput("midreset wbCr0We", {31'd0, bus.wbCr0We}, 32'd0);
    @(posedge CB); #1;

    // Writeback stall with three ops offered, then drain
    applyStimulus(stallOps[0]);
    @(posedge CB); #1;
    applyStimulus(stallOps[1]);
    @(posedge CB); #1;
    applyStimulus(stallOps[2]);
    for (int k = 0; k < 3; k++) begin
      @(negedge CB);
      checkOutput($sformatf("stall%0d dcdReady", k), {31'd0, bus.dcdReady}, 32'd0);
      checkOutput($sformatf("stall%0d srmL2", k), {16'd0, bus.srmL2}, 32'h081F);
      checkOutput($sformatf("stall%0d wbValid", k), {31'd0, bus.wbValid}, 32'd1);
      checkOutput($sformatf("stall%0d wbTag", k), {27'd0, bus.wbTag}, 32'd10);
      checkOutput($sformatf("stall%0d wbData", k), bus.wbData, 32'h2);
      @(posedge CB); #1;
    end
    bus.wbAccept = 1'b1;
    @(negedge CB);
    checkOutput("release dcdReady", {31'd0, bus.dcdReady}, 32'd1);
    @(posedge CB); #1;
    bus.dcdValid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      @(negedge CB);
      checkOutput($sformatf("drain%0d wbValid", k), {31'd0, bus.wbValid}, 32'd1);
      checkOutput($sformatf("drain%0d wbTag", k), {27'd0, bus.wbTag}, {27'd0, stallOps[k].tag});
      checkOutput($sformatf("drain%0d wbData", k), bus.wbData, stallOps[k].expData);
      if (k == 1)
        checkOutput("drain1 srmL2", {16'd0, bus.srmL2}, 32'h0C1F);
      @(posedge CB); #1;
    end
    @(negedge CB);
    checkOutput("drained wbValid", {31'd0, bus.wbValid}, 32'd0);
    checkOutput("drained enNeg", {31'd0, bus.exeSrmUnitEn_NEG}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
